// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard and halt sequencer: load-use bubbles, taken-branch flush, HLT drain to a parked state.
// Optional load-use stall counter is built only when HAZ_STALL_CNT_EN is defined.
module id_ex_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_branch_taken,
  input  logic        id_hlt,
  input  logic        idex_memread,
  input  logic [3:0]  idex_dst,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          halted_q;
  logic          lu;

  // Register 0 is hardwired, so a load targeting it can never feed a consumer.
  assign lu = idex_memread && (idex_dst != 4'd0) &&
              ((id_uses_rs && (id_rs == idex_dst)) ||
               (id_uses_rt && (id_rt == idex_dst)));

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    case (state_q)
      RUN: begin
        if (lu) begin
          ifid_flush  = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_hlt) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b0;
          state_d     = DRAIN;
          dcnt_d      = DW'(DRAIN_CYCLES);
        end else if (id_branch_taken) begin
          pc_wen      = 1'b1;
          ifid_wen    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b0;
        end else begin
          pc_wen      = 1'b1;
          ifid_wen    = 1'b1;
          ifid_flush  = 1'b0;
          idex_bubble = 1'b0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q - DW'(1);
        if (dcnt_q == DW'(1)) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
        dcnt_d  = '0;
      end
    endcase
    // Hold the pipeline frozen with NOPs for as long as reset is asserted.
    if (!rst) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      dcnt_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign halted = halted_q;

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        lu_stall;

  assign lu_stall = (state_q == RUN) && lu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 16'h0000;
    end else if (lu_stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: directed hazard/halt/reset cases plus
// randomized traffic against a cycle-indexed reference model.
module tb_id_ex_hazard_ctrl;

  localparam int DRAIN = 3;
`ifdef HAZ_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  idRs = '0, idRt = '0, idexDst = '0;
  logic        idUsesRs = 0, idUsesRt = 0, idBranchTaken = 0, idHlt = 0, idexMemread = 0;
  logic        pcWen, ifidWen, ifidFlush, idexBubble, haltedOut;
  logic [15:0] stallCnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hltCyc = -1;
  int expStall = 0;

  id_ex_hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .id_rs(idRs), .id_rt(idRt), .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt),
    .id_branch_taken(idBranchTaken), .id_hlt(idHlt),
    .idex_memread(idexMemread), .idex_dst(idexDst),
    .pc_wen(pcWen), .ifid_wen(ifidWen), .ifid_flush(ifidFlush),
    .idex_bubble(idexBubble), .halted(haltedOut), .stall_cnt(stallCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, observed, expected, cyc, $time);
    end
  endtask

  // One pipeline cycle: drive ID/EX view, check against the model, then advance the model.
  task automatic applyStimulus(input logic [3:0] rs, input logic [3:0] rt, input logic urs,
                               input logic urt, input logic br, input logic hlt,
                               input logic mr, input logic [3:0] dst);
    bit   running, hazard;
    logic ePc, eIfid, eFlush, eBub, eHalt;
    @(negedge clk);
    idRs = rs; idRt = rt; idUsesRs = urs; idUsesRt = urt;
    idBranchTaken = br; idHlt = hlt; idexMemread = mr; idexDst = dst;
    #1;
    running = (hltCyc < 0);
    hazard  = mr && (dst != 0) && ((urs && rs == dst) || (urt && rt == dst));
    eHalt   = 1'b0;
    if (!running) begin
      {ePc, eIfid, eFlush, eBub} = 4'b0011;
      eHalt = (cyc >= hltCyc + 1 + DRAIN);
    end else if (hazard) {ePc, eIfid, eFlush, eBub} = 4'b0001;
    else if (hlt)        {ePc, eIfid, eFlush, eBub} = 4'b0010;
    else if (br)         {ePc, eIfid, eFlush, eBub} = 4'b1110;
    else                 {ePc, eIfid, eFlush, eBub} = 4'b1100;
    checkOutput("pc_wen", 16'(pcWen), 16'(ePc));
    checkOutput("ifid_wen", 16'(ifidWen), 16'(eIfid));
    checkOutput("ifid_flush", 16'(ifidFlush), 16'(eFlush));
    checkOutput("idex_bubble", 16'(idexBubble), 16'(eBub));
    checkOutput("halted", 16'(haltedOut), 16'(eHalt));
    checkOutput("stall_cnt", stallCnt, CNT_EN ? 16'(expStall) : 16'h0000);
    if (running && hazard) begin
      if (expStall < 16'hFFFF) expStall++;
    end else if (running && hlt) begin
      hltCyc = cyc;
    end
    cyc++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    idRs = '0; idRt = '0; idUsesRs = 0; idUsesRt = 0;
    idBranchTaken = 0; idHlt = 0; idexMemread = 0; idexDst = '0;
    #1;
    checkOutput("rst_pc_wen", 16'(pcWen), 16'h0);
    checkOutput("rst_ifid_wen", 16'(ifidWen), 16'h0);
    checkOutput("rst_ifid_flush", 16'(ifidFlush), 16'h1);
    checkOutput("rst_idex_bubble", 16'(idexBubble), 16'h1);
    checkOutput("rst_halted", 16'(haltedOut), 16'h0);
    checkOutput("rst_stall_cnt", stallCnt, 16'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_pc_wen", 16'(pcWen), 16'h0);
    checkOutput("rst_hold_halted", 16'(haltedOut), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    hltCyc = -1;
    expStall = 0;
  endtask

  task automatic randStep(input bit allowHlt);
    logic hlt;
    hlt = allowHlt && ($urandom_range(0, 29) == 0);
    applyStimulus(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), hlt,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
  endtask

  initial begin
    doReset();

    // Load-use on rs, then the load moves on and the stall clears.
    applyStimulus(4'd5, 4'd0, 1, 0, 0, 0, 1, 4'd5);
    applyStimulus(4'd5, 4'd0, 1, 0, 0, 0, 0, 4'd5);
    // Register 0 and unused operand never stall.
    applyStimulus(4'd0, 4'd0, 1, 1, 0, 0, 1, 4'd0);
    applyStimulus(4'd0, 4'd3, 0, 0, 0, 0, 1, 4'd3);
    // Lone taken branch, then straight-line.
    applyStimulus(4'd1, 4'd2, 1, 1, 1, 0, 0, 4'd0);
    applyStimulus(4'd1, 4'd2, 1, 1, 0, 0, 0, 4'd0);
    // Stall beats branch; branch flushes next cycle.
    applyStimulus(4'd2, 4'd0, 1, 0, 1, 0, 1, 4'd2);
    applyStimulus(4'd2, 4'd0, 1, 0, 1, 0, 0, 4'd2);
    // Stall beats HLT, HLT accepted next cycle, then park for 20+ cycles.
    applyStimulus(4'd0, 4'd7, 0, 1, 0, 1, 1, 4'd7);
    applyStimulus(4'd0, 4'd7, 0, 1, 0, 1, 0, 4'd7);
    for (int i = 0; i < 24; i++) randStep(1'b1);
    doReset();

    // Reset while draining.
    applyStimulus(4'd0, 4'd0, 0, 0, 0, 1, 0, 4'd0);
    applyStimulus(4'd1, 4'd1, 1, 1, 1, 0, 1, 4'd1);
    doReset();
    applyStimulus(4'd0, 4'd0, 0, 0, 0, 0, 0, 4'd0);

    for (int i = 0; i < 500; i++) begin
      if (hltCyc >= 0 && ($urandom_range(0, 9) == 0 || cyc > hltCyc + 12)) doReset();
      else randStep(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
